// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit. Shift-add multiply and
//            restoring divide on operand magnitudes, one bit per cycle, with a
//            start/busy/done handshake towards the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [CW-1:0]    c_iter = CW'(WIDTH);
  localparam logic [CW-1:0]    c_one  = CW'(1);
  localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ones = '1;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [2:0]         r_op;
  logic               r_neg;
  logic               r_fast;
  logic [WIDTH-1:0]   r_fast_val;
  // multiply: product accumulator; divide: partial remainder in low half
  logic [2*WIDTH-1:0] r_acc;
  // multiply: multiplier (shifts right); divide: dividend/quotient (shifts left)
  logic [WIDTH-1:0]   r_opa;
  // multiply: multiplicand (shifts left); divide: divisor in low half
  logic [2*WIDTH-1:0] r_opb;
  logic [WIDTH-1:0]   r_result;

  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_res_neg;
  logic               w_fast;
  logic [WIDTH-1:0]   w_fast_val;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  // Decode the incoming op: operand signedness, magnitudes, result sign, fast paths
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (funct3)
      3'b001:         begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'b010:         begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
      3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      default:        begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
    endcase
    w_neg_a = w_a_signed & a[WIDTH-1];
    w_neg_b = w_b_signed & b[WIDTH-1];
    w_mag_a = w_neg_a ? -a : a;
    w_mag_b = w_neg_b ? -b : b;
    // remainder follows the dividend sign; everything else negates on sign mismatch
    if (funct3[2] && funct3[1]) begin
      w_res_neg = w_neg_a;
    end else begin
      w_res_neg = w_neg_a ^ w_neg_b;
    end
    w_fast     = 1'b0;
    w_fast_val = '0;
    if (funct3[2] && (b == '0)) begin
      w_fast     = 1'b1;
      w_fast_val = funct3[1] ? a : c_ones;
    end else if (funct3[2] && !funct3[0] && (a == c_min) && (b == c_ones)) begin
      w_fast     = 1'b1;
      w_fast_val = funct3[1] ? '0 : c_min;
    end
  end

  // One restoring-division trial subtraction per cycle
  always_comb begin
    w_shift = {r_acc[WIDTH-1:0], r_opa[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_opb[WIDTH-1:0]};
  end

  // Final result: sign fixup and half/quotient/remainder select
  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -r_opa : r_opa;
    w_rem  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    if (r_fast) begin
      w_final = r_fast_val;
    end else if (r_op[2]) begin
      w_final = r_op[1] ? w_rem : w_quo;
    end else if (r_op[1:0] == 2'b00) begin
      w_final = w_prod[WIDTH-1:0];
    end else begin
      w_final = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM and datapath registers. CALC runs WIDTH iteration cycles
  // (counter WIDTH..1) followed by one finalize cycle (counter 0); fast paths
  // load the counter with 0 so they go straight to the finalize cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_idle;
      r_count    <= '0;
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_val <= '0;
      r_acc      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_result   <= '0;
    end else if (flush) begin
      r_state <= c_idle;
      r_count <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_op       <= funct3;
            r_neg      <= w_res_neg;
            r_fast     <= w_fast;
            r_fast_val <= w_fast_val;
            r_count    <= w_fast ? '0 : c_iter;
            r_acc      <= '0;
            r_opa      <= w_mag_a;
            r_opb      <= {{WIDTH{1'b0}}, w_mag_b};
            r_state    <= c_calc;
          end
        end
        c_calc: begin
          if (r_count != '0) begin
            r_count <= r_count - c_one;
            if (r_op[2]) begin
              r_opa <= {r_opa[WIDTH-2:0], ~w_diff[WIDTH]};
              r_acc <= {{WIDTH{1'b0}}, (w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0])};
            end else begin
              if (r_opa[0]) begin
                r_acc <= r_acc + r_opb;
              end
              r_opa <= r_opa >> 1;
              r_opb <= r_opb << 1;
            end
          end else begin
            r_result <= w_final;
            r_state  <= c_done;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign busy   = (r_state != c_idle);
  assign done   = (r_state == c_done);
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit: directed RV32M cases,
//            randomized ops against an arithmetic reference model, flush,
//            start-while-busy, and asynchronous reset mid-operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         flush;
  logic [2:0]   funct3;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks;
  int errors;
  logic [W-1:0] last_res;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M arithmetic, straight from the ISA definition
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int sx;
    int sy;
    sx = x;
    sy = y;
    case (f)
      3'b000: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'b001: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
      3'b010: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
      3'b011: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(sx / sy);
      end
      3'b101: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sx % sy);
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  // Edges from the start edge to the edge that enters DONE
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && y == 0) return 1;
    if ((f == 3'b100 || f == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op and follow it to completion; optionally poke start while busy
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input bit poke);
    logic [31:0] exp;
    int exp_lat;
    int lat;
    bit busy_ok;
    exp = ref_result(f, av, bv);
    exp_lat = ref_latency(f, av, bv);
    @(negedge clk);
    start = 1'b1; funct3 = f; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom_range(0, 7));
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (poke && n == 4) begin
        start = 1'b1; funct3 = 3'b100; a = 32'd5; b = 32'd0;
      end
      if (poke && n == 9) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy_held"}, {31'b0, busy_ok & busy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
    chk({tag, "_result_hold"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    last_res = '0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed RV32M cases, including division fast paths
    run_op("mul_neg",    3'b000, 32'd7,          32'hFFFF_FFFD, 1'b0);
    run_op("mulh_min",   3'b001, 32'h8000_0000,  32'h8000_0000, 1'b0);
    run_op("mulhu_min",  3'b011, 32'h8000_0000,  32'h8000_0000, 1'b0);
    run_op("mulhsu",     3'b010, 32'hFFFF_FFFF,  32'd2,         1'b0);
    run_op("divu",       3'b101, 32'd100,        32'd7,         1'b0);
    run_op("remu",       3'b111, 32'd100,        32'd7,         1'b0);
    run_op("div_neg",    3'b100, 32'hFFFF_FFF9,  32'd2,         1'b0);
    run_op("rem_neg",    3'b110, 32'hFFFF_FFF9,  32'd2,         1'b0);
    run_op("div_zero",   3'b100, 32'd5,          32'd0,         1'b0);
    run_op("rem_zero",   3'b110, 32'd5,          32'd0,         1'b0);
    run_op("divu_zero",  3'b101, 32'd9,          32'd0,         1'b0);
    run_op("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);

    // Randomized ops with corner-biased operands
    for (int i = 0; i < 24; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b0);
    end

    // start raised while busy must be ignored
    run_op("start_busy", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // flush in CALC cycle 10: no done, result unchanged
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_result", result, last_res);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("flush_no_done", 32'(seen), 32'd0);

    // start together with flush in IDLE is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("start_flush_done", {31'b0, done}, 32'd0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
